// File: rtl/eth_rx_pkg.sv
// rtl/eth_rx_pkg.sv - shared types and helpers for the Ethernet RX filter
// Purpose: buffer word layout, write-side FSM states, broadcast address and
//          a saturating counter increment used by the drop/good counters.
package eth_rx_pkg;

  // One buffered beat: last flag, byte enables, payload.
  typedef struct packed {
    logic        last;
    logic [7:0]  keep;
    logic [63:0] data;
  } rx_word_t;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    BODY,
    DISCARD
  } wr_state_t;

  localparam logic [47:0] ETH_BCAST = 48'hFFFF_FFFF_FFFF;

  // Counters stick at all-ones instead of wrapping.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/eth_rx_buf_ram.sv
// rtl/eth_rx_buf_ram.sv - simple dual-port frame buffer RAM
// Purpose: one write port, one read port with a registered (1-cycle) output.
// Ports:
//   clk_i    clock
//   we_i     write enable;  waddr_i / wdata_i  write address and word
//   re_i     read enable;   raddr_i            read address
//   rdata_o  read word, valid the cycle after re_i
module eth_rx_buf_ram
  import eth_rx_pkg::*;
#(
  parameter int DEPTH_LOG2 = 9
) (
  input  logic                  clk_i,
  input  logic                  we_i,
  input  logic [DEPTH_LOG2-1:0] waddr_i,
  input  rx_word_t              wdata_i,
  input  logic                  re_i,
  input  logic [DEPTH_LOG2-1:0] raddr_i,
  output rx_word_t              rdata_o
);

  rx_word_t mem_q [2**DEPTH_LOG2];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_o <= mem_q[raddr_i];
    end
  end

endmodule

// File: rtl/eth_rx_filter.sv
// rtl/eth_rx_filter.sv - store-and-forward Ethernet RX frame filter
// Purpose: buffers each MAC RX frame, keeps it only if FCS is good, the
//          destination is MAC_ADDR or broadcast and the ethertype is
//          ETHERTYPE, then replays kept frames on a back-pressurable stream.
// Ports:
//   clk156, sys_rst        clock, synchronous active-high reset
//   s_axis_rx_*            MAC RX beats (no back-pressure); tuser on tlast = FCS ok
//   m_axis_*               filtered output stream with tready
//   cnt_good               frames committed
//   cnt_drop_fcs           frames dropped for bad FCS
//   cnt_drop_filter        frames dropped for address/ethertype mismatch or runt
//   cnt_drop_ovf           frames dropped because the buffer was full
module eth_rx_filter
  import eth_rx_pkg::*;
#(
  parameter int          DEPTH_LOG2 = 9,
  parameter logic [47:0] MAC_ADDR   = 48'h000A35000001,
  parameter logic [15:0] ETHERTYPE  = 16'h88B5
) (
  input  logic        clk156,
  input  logic        sys_rst,
  input  logic        s_axis_rx_tvalid,
  input  logic [63:0] s_axis_rx_tdata,
  input  logic [7:0]  s_axis_rx_tkeep,
  input  logic        s_axis_rx_tlast,
  input  logic        s_axis_rx_tuser,
  output logic        m_axis_tvalid,
  input  logic        m_axis_tready,
  output logic [63:0] m_axis_tdata,
  output logic [7:0]  m_axis_tkeep,
  output logic        m_axis_tlast,
  output logic [31:0] cnt_good,
  output logic [31:0] cnt_drop_fcs,
  output logic [31:0] cnt_drop_filter,
  output logic [31:0] cnt_drop_ovf
);

  localparam int             PW       = DEPTH_LOG2 + 1;
  localparam logic [PW-1:0]  PTR_ONE  = PW'(1);
  localparam logic [PW-1:0]  DEPTH_W  = {1'b1, {DEPTH_LOG2{1'b0}}};

  // ---------------------------------------------------------------- write side
  wr_state_t     wr_state_q, wr_state_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] wr_commit_q, wr_commit_d;
  logic          match_q, match_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   cnt_good_q, cnt_good_d;
  logic [31:0]   cnt_fcs_q, cnt_fcs_d;
  logic [31:0]   cnt_filter_q, cnt_filter_d;
  logic [31:0]   cnt_ovf_q, cnt_ovf_d;

  // ---------------------------------------------------------------- read side
  // rd_ptr_q retires a word only when it leaves on m_axis, so words parked in
  // the skid register still count as occupied; rd_addr_q is the RAM fetch
  // pointer and runs up to two words ahead of rd_ptr_q.
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] rd_addr_q;
  logic          inflight_q;
  logic [1:0]    sk_cnt_q, sk_cnt_d;
  rx_word_t      sk0_q, sk0_d;
  rx_word_t      sk1_q, sk1_d;

  logic          ram_we;
  rx_word_t      ram_wdata;
  rx_word_t      ram_rdata;
  logic          rd_issue;
  logic          pop;
  logic          push;
  logic [2:0]    occ;
  logic          full;
  logic [47:0]   rx_dst;
  logic [15:0]   rx_type;
  logic          dst_ok;
  logic          type_ok;

  // Byte 0 on the wire is tdata[7:0] and the MSB of the address.
  assign rx_dst  = {s_axis_rx_tdata[7:0],   s_axis_rx_tdata[15:8],
                    s_axis_rx_tdata[23:16], s_axis_rx_tdata[31:24],
                    s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]};
  // Bytes 12-13 sit in lanes 4-5 of beat 1.
  assign rx_type = {s_axis_rx_tdata[39:32], s_axis_rx_tdata[47:40]};
  assign dst_ok  = (rx_dst == MAC_ADDR) || (rx_dst == ETH_BCAST);
  assign type_ok = (rx_type == ETHERTYPE);

  // Uses wr_ptr, so an uncommitted frame in progress reserves its space.
  assign full = ((wr_ptr_q - rd_ptr_q) == DEPTH_W);

  always_comb begin
    wr_state_d   = wr_state_q;
    wr_ptr_d     = wr_ptr_q;
    wr_commit_d  = wr_commit_q;
    match_d      = match_q;
    ovf_d        = ovf_q;
    cnt_good_d   = cnt_good_q;
    cnt_fcs_d    = cnt_fcs_q;
    cnt_filter_d = cnt_filter_q;
    cnt_ovf_d    = cnt_ovf_q;
    ram_we       = 1'b0;
    ram_wdata.last = s_axis_rx_tlast;
    ram_wdata.keep = s_axis_rx_tkeep;
    ram_wdata.data = s_axis_rx_tdata;

    if (s_axis_rx_tvalid) begin
      unique case (wr_state_q)
        IDLE: begin
          if (full) begin
            wr_ptr_d = wr_commit_q;
            if (s_axis_rx_tlast) begin
              cnt_ovf_d = sat_inc(cnt_ovf_q);
            end else begin
              ovf_d      = 1'b1;
              wr_state_d = DISCARD;
            end
          end else if (s_axis_rx_tlast) begin
            // One-beat runt: nothing is advanced, so nothing to roll back.
            cnt_filter_d = sat_inc(cnt_filter_q);
          end else begin
            ram_we     = 1'b1;
            wr_ptr_d   = wr_ptr_q + PTR_ONE;
            match_d    = dst_ok;
            ovf_d      = 1'b0;
            wr_state_d = HDR;
          end
        end

        HDR: begin
          if (s_axis_rx_tlast) begin
            wr_ptr_d     = wr_commit_q;
            cnt_filter_d = sat_inc(cnt_filter_q);
            wr_state_d   = IDLE;
          end else if (!(match_q && type_ok)) begin
            wr_ptr_d   = wr_commit_q;
            ovf_d      = 1'b0;
            wr_state_d = DISCARD;
          end else if (full) begin
            wr_ptr_d   = wr_commit_q;
            ovf_d      = 1'b1;
            wr_state_d = DISCARD;
          end else begin
            ram_we     = 1'b1;
            wr_ptr_d   = wr_ptr_q + PTR_ONE;
            wr_state_d = BODY;
          end
        end

        BODY: begin
          if (full) begin
            wr_ptr_d = wr_commit_q;
            if (s_axis_rx_tlast) begin
              cnt_ovf_d  = sat_inc(cnt_ovf_q);
              wr_state_d = IDLE;
            end else begin
              ovf_d      = 1'b1;
              wr_state_d = DISCARD;
            end
          end else begin
            ram_we = 1'b1;
            if (s_axis_rx_tlast) begin
              if (s_axis_rx_tuser) begin
                wr_ptr_d    = wr_ptr_q + PTR_ONE;
                wr_commit_d = wr_ptr_q + PTR_ONE;
                cnt_good_d  = sat_inc(cnt_good_q);
              end else begin
                wr_ptr_d  = wr_commit_q;
                cnt_fcs_d = sat_inc(cnt_fcs_q);
              end
              wr_state_d = IDLE;
            end else begin
              wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
          end
        end

        DISCARD: begin
          if (s_axis_rx_tlast) begin
            if (ovf_q) begin
              cnt_ovf_d = sat_inc(cnt_ovf_q);
            end else if (!s_axis_rx_tuser) begin
              cnt_fcs_d = sat_inc(cnt_fcs_q);
            end else begin
              cnt_filter_d = sat_inc(cnt_filter_q);
            end
            ovf_d      = 1'b0;
            wr_state_d = IDLE;
          end
        end

        default: wr_state_d = IDLE;
      endcase
    end
  end

  eth_rx_buf_ram #(
    .DEPTH_LOG2(DEPTH_LOG2)
  ) u_ram (
    .clk_i   (clk156),
    .we_i    (ram_we),
    .waddr_i (wr_ptr_q[DEPTH_LOG2-1:0]),
    .wdata_i (ram_wdata),
    .re_i    (rd_issue),
    .raddr_i (rd_addr_q[DEPTH_LOG2-1:0]),
    .rdata_o (ram_rdata)
  );

  // Skid occupancy includes the word still in the RAM output pipeline; a new
  // fetch may start whenever the total after this cycle's pop stays <= 2.
  assign pop      = (sk_cnt_q != 2'd0) && m_axis_tready;
  assign push     = inflight_q;
  assign occ      = {1'b0, sk_cnt_q} + {2'b00, inflight_q};
  assign rd_issue = (rd_addr_q != wr_commit_q) &&
                    ((occ < 3'd2) || ((occ == 3'd2) && pop));

  always_comb begin
    sk0_d    = sk0_q;
    sk1_d    = sk1_q;
    sk_cnt_d = sk_cnt_q + {1'b0, push} - {1'b0, pop};
    if (pop) begin
      if (sk_cnt_q == 2'd2) begin
        sk0_d = sk1_q;
        if (push) begin
          sk1_d = ram_rdata;
        end
      end else if (push) begin
        sk0_d = ram_rdata;
      end
    end else if (push) begin
      if (sk_cnt_q == 2'd0) begin
        sk0_d = ram_rdata;
      end else begin
        sk1_d = ram_rdata;
      end
    end
  end

  always_ff @(posedge clk156) begin
    if (sys_rst) begin
      wr_state_q   <= IDLE;
      wr_ptr_q     <= '0;
      wr_commit_q  <= '0;
      match_q      <= 1'b0;
      ovf_q        <= 1'b0;
      cnt_good_q   <= '0;
      cnt_fcs_q    <= '0;
      cnt_filter_q <= '0;
      cnt_ovf_q    <= '0;
      rd_ptr_q     <= '0;
      rd_addr_q    <= '0;
      inflight_q   <= 1'b0;
      sk_cnt_q     <= 2'd0;
      sk0_q        <= '0;
      sk1_q        <= '0;
    end else begin
      wr_state_q   <= wr_state_d;
      wr_ptr_q     <= wr_ptr_d;
      wr_commit_q  <= wr_commit_d;
      match_q      <= match_d;
      ovf_q        <= ovf_d;
      cnt_good_q   <= cnt_good_d;
      cnt_fcs_q    <= cnt_fcs_d;
      cnt_filter_q <= cnt_filter_d;
      cnt_ovf_q    <= cnt_ovf_d;
      rd_ptr_q     <= pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
      rd_addr_q    <= rd_issue ? rd_addr_q + PTR_ONE : rd_addr_q;
      inflight_q   <= rd_issue;
      sk_cnt_q     <= sk_cnt_d;
      sk0_q        <= sk0_d;
      sk1_q        <= sk1_d;
    end
  end

  assign m_axis_tvalid   = (sk_cnt_q != 2'd0);
  assign m_axis_tdata    = sk0_q.data;
  assign m_axis_tkeep    = sk0_q.keep;
  assign m_axis_tlast    = sk0_q.last;
  assign cnt_good        = cnt_good_q;
  assign cnt_drop_fcs    = cnt_fcs_q;
  assign cnt_drop_filter = cnt_filter_q;
  assign cnt_drop_ovf    = cnt_ovf_q;

endmodule

// File: tb/tb_eth_rx_filter.sv
// tb/tb_eth_rx_filter.sv - self-checking bench for eth_rx_filter
module tb_eth_rx_filter;

  localparam logic [47:0] MAC = 48'h000A35000001;
  localparam logic [47:0] BC  = 48'hFFFFFFFFFFFF;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        sys_rst;
  logic        in_tvalid;
  logic [63:0] in_tdata;
  logic [7:0]  in_tkeep;
  logic        in_tlast;
  logic        in_tuser;
  logic        target;
  logic        a_tvalid;
  logic        b_tvalid;
  assign a_tvalid = in_tvalid & ~target;
  assign b_tvalid = in_tvalid & target;

  logic        m_tvalid, m_tready, m_tlast;
  logic [63:0] m_tdata;
  logic [7:0]  m_tkeep;
  logic [31:0] c_good, c_fcs, c_filter, c_ovf;

  logic        s_tvalid, s_tready, s_tlast;
  logic [63:0] s_tdata;
  logic [7:0]  s_tkeep;
  logic [31:0] s_good, s_fcs, s_filter, s_ovf;

  eth_rx_filter dut (
    .clk156(clk), .sys_rst(sys_rst),
    .s_axis_rx_tvalid(a_tvalid), .s_axis_rx_tdata(in_tdata), .s_axis_rx_tkeep(in_tkeep),
    .s_axis_rx_tlast(in_tlast), .s_axis_rx_tuser(in_tuser),
    .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tdata(m_tdata),
    .m_axis_tkeep(m_tkeep), .m_axis_tlast(m_tlast),
    .cnt_good(c_good), .cnt_drop_fcs(c_fcs), .cnt_drop_filter(c_filter), .cnt_drop_ovf(c_ovf)
  );

  eth_rx_filter #(.DEPTH_LOG2(4)) dut_s (
    .clk156(clk), .sys_rst(sys_rst),
    .s_axis_rx_tvalid(b_tvalid), .s_axis_rx_tdata(in_tdata), .s_axis_rx_tkeep(in_tkeep),
    .s_axis_rx_tlast(in_tlast), .s_axis_rx_tuser(in_tuser),
    .m_axis_tvalid(s_tvalid), .m_axis_tready(s_tready), .m_axis_tdata(s_tdata),
    .m_axis_tkeep(s_tkeep), .m_axis_tlast(s_tlast),
    .cnt_good(s_good), .cnt_drop_fcs(s_fcs), .cnt_drop_filter(s_filter), .cnt_drop_ovf(s_ovf)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  beat_t        exp_q[$];
  byte unsigned fr[$];
  int           e_good, e_fcs, e_filter, e_ovf;
  int           checks = 0;
  int           errors = 0;
  int           out_beats = 0;
  logic [7:0]   last_keep = 8'h00;
  int           s_beats = 0;
  int           s_lasts = 0;
  logic [63:0]  s_first_data = 64'h0;
  logic         rnd_ready = 1'b0;
  logic         tready_fix = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame image: dst, fixed src, ethertype, seeded payload.
  task automatic build(input logic [47:0] dst, input logic [15:0] etype, input int len, input int seed);
    byte unsigned b;
    fr.delete();
    for (int i = 0; i < len; i++) begin
      if (i < 6)        b = dst[47-8*i -: 8];
      else if (i < 12)  b = 8'(8'h10 + i);
      else if (i == 12) b = etype[15:8];
      else if (i == 13) b = etype[7:0];
      else              b = 8'((seed * 31 + i * 7) & 8'hFF);
      fr.push_back(b);
    end
  endtask

  function automatic beat_t make_beat(input int b);
    beat_t r;
    int nb;
    r.data = '0;
    r.keep = '0;
    nb = (fr.size() + 7) / 8;
    for (int i = 0; i < 8; i++) begin
      if (b * 8 + i < fr.size()) begin
        r.data[8*i +: 8] = fr[b*8+i];
        r.keep[i] = 1'b1;
      end
    end
    r.last = (b == nb - 1);
    return r;
  endfunction

  // Frame-level decision straight from the acceptance rules.
  task automatic model_frame(input bit tuser);
    int nb;
    logic [47:0] d;
    bit ok;
    nb = (fr.size() + 7) / 8;
    if (nb <= 2) begin
      e_filter++;
    end else begin
      d  = {fr[0], fr[1], fr[2], fr[3], fr[4], fr[5]};
      ok = ((d == MAC) || (d == BC)) && (fr[12] == 8'h88) && (fr[13] == 8'hB5);
      if (!tuser)   e_fcs++;
      else if (!ok) e_filter++;
      else begin
        e_good++;
        for (int b = 0; b < nb; b++) exp_q.push_back(make_beat(b));
      end
    end
  endtask

  task automatic send(input bit tuser);
    int nb;
    beat_t bt;
    nb = (fr.size() + 7) / 8;
    if (!target) model_frame(tuser);
    for (int b = 0; b < nb; b++) begin
      bt = make_beat(b);
      @(posedge clk); #1;
      in_tvalid = 1'b1;
      in_tdata  = bt.data;
      in_tkeep  = bt.keep;
      in_tlast  = bt.last;
      in_tuser  = bt.last ? tuser : 1'b0;
    end
    @(posedge clk); #1;
    in_tvalid = 1'b0;
    in_tlast  = 1'b0;
    in_tuser  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk(name, exp_q.size(), 0);
  endtask

  task automatic check_cnts(input string tag);
    @(negedge clk);
    chk({tag, "_good"},   c_good,   e_good);
    chk({tag, "_fcs"},    c_fcs,    e_fcs);
    chk({tag, "_filter"}, c_filter, e_filter);
    chk({tag, "_ovf"},    c_ovf,    e_ovf);
  endtask

  // tready driver for the main instance.
  initial begin
    m_tready = 1'b0;
    forever begin
      @(posedge clk); #1;
      m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : tready_fix;
    end
  end

  // Output compare: every handshake against the model queue, and hold while stalled.
  logic        prev_stall = 1'b0;
  logic [63:0] prev_data;
  logic [7:0]  prev_keep;
  logic        prev_last;
  always @(negedge clk) begin
    beat_t e;
    if (sys_rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) begin
        checks++;
        if (!m_tvalid || m_tdata !== prev_data || m_tkeep !== prev_keep || m_tlast !== prev_last) begin
          errors++;
          $display("FAIL stall_hold: got v=%b d=%h k=%h l=%b held d=%h k=%h l=%b",
                   m_tvalid, m_tdata, m_tkeep, m_tlast, prev_data, prev_keep, prev_last);
        end
      end
      if (m_tvalid && m_tready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got d=%h k=%h l=%b required none", m_tdata, m_tkeep, m_tlast);
        end else begin
          e = exp_q.pop_front();
          if (m_tdata !== e.data || m_tkeep !== e.keep || m_tlast !== e.last) begin
            errors++;
            $display("FAIL beat: got d=%h k=%h l=%b required d=%h k=%h l=%b",
                     m_tdata, m_tkeep, m_tlast, e.data, e.keep, e.last);
          end
        end
        out_beats++;
        if (m_tlast) last_keep = m_tkeep;
      end
      prev_stall = m_tvalid && !m_tready;
      prev_data  = m_tdata;
      prev_keep  = m_tkeep;
      prev_last  = m_tlast;
    end
  end

  always @(negedge clk) begin
    if (!sys_rst && s_tvalid && s_tready) begin
      if (s_beats == 0) s_first_data = s_tdata;
      s_beats++;
      if (s_tlast && s_tkeep == 8'hFF) s_lasts++;
    end
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int nb;
    beat_t w0;
    sys_rst = 1'b1;
    in_tvalid = 1'b0; in_tdata = '0; in_tkeep = '0; in_tlast = 1'b0; in_tuser = 1'b0;
    target = 1'b0; s_tready = 1'b0;
    e_good = 0; e_fcs = 0; e_filter = 0; e_ovf = 0;
    repeat (3) @(posedge clk);
    #1 sys_rst = 1'b0;
    @(negedge clk);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_tdata",  m_tdata,  0);
    chk("rst_tlast",  m_tlast,  0);
    check_cnts("rst");

    // 1: 64-byte unicast good frame.
    tready_fix = 1'b1;
    idle(2);
    base = out_beats;
    build(MAC, 16'h88B5, 64, 1);
    send(1'b1);
    drain("t1_drain", 200);
    chk("t1_beats", out_beats - base, 8);
    chk("t1_lastkeep", last_keep, 8'hFF);
    chk("t1_cnt_good", c_good, 1);
    check_cnts("t1");

    // 2: bad FCS then 60-byte broadcast.
    base = out_beats;
    build(MAC, 16'h88B5, 64, 1);
    send(1'b0);
    build(BC, 16'h88B5, 60, 2);
    send(1'b1);
    drain("t2_drain", 200);
    chk("t2_beats", out_beats - base, 8);
    chk("t2_lastkeep", last_keep, 8'h0F);
    chk("t2_cnt_fcs", c_fcs, 1);
    chk("t2_cnt_good", c_good, 2);
    check_cnts("t2");

    // 3: filter drops and runt boundaries, then a minimal 3-beat good frame.
    base = out_beats;
    build(48'h020000000009, 16'h88B5, 64, 3); send(1'b1);
    build(MAC, 16'h0800, 64, 4);               send(1'b1);
    build(MAC, 16'h88B5, 6, 5);                send(1'b1);
    build(MAC, 16'h88B5, 16, 6);               send(1'b1);
    idle(20);
    chk("t3_beats_none", out_beats - base, 0);
    chk("t3_cnt_filter", c_filter, 4);
    build(MAC, 16'h88B5, 17, 7);               send(1'b1);
    drain("t3_drain", 200);
    chk("t3_beats", out_beats - base, 3);
    chk("t3_lastkeep", last_keep, 8'h01);
    check_cnts("t3");

    // 4: 16-word instance stalled; third 48-byte frame overflows.
    target = 1'b1;
    build(MAC, 16'h88B5, 48, 9);
    w0 = make_beat(0);
    for (int k = 0; k < 3; k++) send(1'b1);
    idle(5);
    chk("t4_good", s_good, 2);
    chk("t4_ovf", s_ovf, 1);
    chk("t4_beats_stalled", s_beats, 0);
    s_tready = 1'b1;
    idle(40);
    chk("t4_beats", s_beats, 12);
    chk("t4_lasts", s_lasts, 2);
    chk("t4_first_word", s_first_data, w0.data);
    send(1'b1);
    idle(20);
    chk("t4_good_after", s_good, 3);
    chk("t4_beats_after", s_beats, 18);
    chk("t4_ovf_after", s_ovf, 1);
    target = 1'b0;

    // 5: 200 frames with random back-pressure.
    rnd_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      build((k % 2) ? BC : MAC, 16'h88B5, $urandom_range(64, 1518), 100 + k);
      nb = (fr.size() + 7) / 8;
      send(1'b1);
      idle(2 * nb + 10);
    end
    rnd_ready = 1'b0;
    drain("t5_drain", 5000);
    chk("t5_cnt_good", c_good, 203);
    check_cnts("t5");

    // 6: reset with 5 beats buffered.
    tready_fix = 1'b0;
    idle(3);
    build(MAC, 16'h88B5, 40, 8);
    send(1'b1);
    idle(6);
    sys_rst = 1'b1;
    exp_q.delete();
    e_good = 0; e_fcs = 0; e_filter = 0; e_ovf = 0;
    @(posedge clk); #1;
    sys_rst = 1'b0;
    @(negedge clk);
    chk("t6_tvalid", m_tvalid, 0);
    chk("t6_cnt_good", c_good, 0);
    check_cnts("t6_rst");
    tready_fix = 1'b1;
    idle(2);
    base = out_beats;
    build(BC, 16'h88B5, 100, 10);
    send(1'b1);
    drain("t6_drain", 200);
    chk("t6_beats", out_beats - base, 13);
    chk("t6_lastkeep", last_keep, 8'h0F);
    check_cnts("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
